// File: rtl/y86_pkg.sv
// Shared Y86 instruction-fetch definitions: icode values, instruction size limit,
// fetch FSM states and the byte-address range helper.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam int MAX_INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // 65-bit sum so that base+off wrapping past 2^64-1 is treated as out of range.
    function automatic logic addr_in_range(input logic [63:0] base,
                                           input logic [3:0]  off,
                                           input logic [63:0] last);
        logic [64:0] sum;
        sum = {1'b0, base} + {61'd0, off};
        return sum <= {1'b0, last};
    endfunction

endpackage

// File: rtl/ilen_decode.sv
// Combinational map from a Y86 icode (high nibble of byte 0) to the instruction
// length in bytes.
module ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len
);

    always_comb begin
        len = 4'd1;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
            I_JXX, I_CALL:                     len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      len = 4'd10;
            default:                           len = 4'd1;
        endcase
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Byte-serial instruction fetch controller: reads bytes from pc until the decoded
// length is reached. Define IFETCH_TIMEOUT_EN to abort a fetch whose ack never arrives.
module ifetch_ctrl
    import y86_pkg::*;
#(
    parameter int IMEM_SIZE = 1024,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic [0:79] instr,
    output logic [3:0]  instr_len,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        imem_error,
    output logic        busy
);

    localparam logic [63:0] LAST_ADDR = 64'(IMEM_SIZE - 1);

    state_t      state;
    logic [63:0] pc_q;
    logic [3:0]  cnt;
    logic [3:0]  len_q;
    logic [3:0]  dec_len;
    logic [3:0]  cnt_inc;
    logic [3:0]  len_eff;
    logic [63:0] addr_inc;
    logic        timed_out;
    logic [0:8*MAX_INSTR_BYTES-1] instr_wr;

    ilen_decode u_ilen_decode (
        .icode (mem_rdata[7:4]),
        .len   (dec_len)
    );

    assign cnt_inc  = cnt + 4'd1;
    // Byte 0 is still on the bus when it is acked, so decode it directly there.
    assign len_eff  = (cnt == 4'd0) ? dec_len : len_q;
    assign addr_inc = pc_q + {60'd0, cnt_inc};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_INSTR_BYTES; gi++) begin : g_byte
            assign instr_wr[8*gi +: 8] = (cnt == 4'(gi)) ? mem_rdata : instr[8*gi +: 8];
        end
    endgenerate

`ifdef IFETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || state != S_REQ || mem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign timed_out = !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc_q        <= '0;
            cnt         <= '0;
            len_q       <= '0;
            instr       <= '0;
            instr_len   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc_q      <= pc;
                        cnt       <= '0;
                        len_q     <= '0;
                        instr     <= '0;
                        instr_len <= '0;
                        busy      <= 1'b1;
                        if (addr_in_range(pc, 4'd0, LAST_ADDR)) begin
                            state    <= S_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end else begin
                            state       <= S_ERR;
                            instr_valid <= 1'b1;
                            imem_error  <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            state       <= S_ERR;
                            mem_req     <= 1'b0;
                            instr_len   <= cnt;
                            instr_valid <= 1'b1;
                            imem_error  <= 1'b1;
                        end else begin
                            instr <= instr_wr;
                            cnt   <= cnt_inc;
                            if (cnt == 4'd0) begin
                                len_q <= dec_len;
                            end
                            if (cnt_inc == len_eff) begin
                                state       <= S_DONE;
                                mem_req     <= 1'b0;
                                instr_len   <= len_eff;
                                instr_valid <= 1'b1;
                            end else if (!addr_in_range(pc_q, cnt_inc, LAST_ADDR)) begin
                                // Next byte would fall outside memory: never put it on the bus.
                                state       <= S_ERR;
                                mem_req     <= 1'b0;
                                instr_len   <= cnt_inc;
                                instr_valid <= 1'b1;
                                imem_error  <= 1'b1;
                            end else begin
                                mem_addr <= addr_inc;
                            end
                        end
                    end else if (timed_out) begin
                        state       <= S_ERR;
                        mem_req     <= 1'b0;
                        instr_len   <= cnt;
                        instr_valid <= 1'b1;
                        imem_error  <= 1'b1;
                    end
                end

                S_DONE, S_ERR: begin
                    if (instr_ready) begin
                        state       <= S_IDLE;
                        instr_valid <= 1'b0;
                        imem_error  <= 1'b0;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    imem_error  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter IMEM_SIZE, default 1024, instruction memory size in bytes; legal byte addresses are 0..IMEM_SIZE-1.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for mem_ack (used only when IFETCH_TIMEOUT_EN is defined).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to fetch one instruction at pc.
REQ-006 pc  input  64  byte address of the instruction.
REQ-007 mem_req  output  1  byte read request to instruction memory.
REQ-008 mem_addr  output  64  byte address for mem_req.
REQ-009 mem_ack  input  1  read complete; mem_rdata and mem_err valid this cycle.
REQ-010 mem_rdata  input  8  returned byte.
REQ-011 mem_err  input  1  memory fault, qualified by mem_ack.
REQ-012 instr  output  [0:79]  assembled instruction, byte k at bits [8k:8k+7].
REQ-013 instr_len  output  4  instruction length in bytes (1..10).
REQ-014 instr_valid  output  1  instr, instr_len and imem_error valid.
REQ-015 instr_ready  input  1  consumer accepts the result.
REQ-016 imem_error  output  1  fetch failed (out-of-range, mem_err or timeout).
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, REQ, DONE, ERR.
REQ-019 IDLE: on start=1, capture pc into pc_q, clear byte count cnt and instr, go to REQ; start in any other state SHALL be ignored.
REQ-020 REQ: mem_req=1 and mem_addr=pc_q+cnt, held stable until mem_ack.
REQ-021 Before issuing each byte, if pc_q+cnt > IMEM_SIZE-1, go to ERR without asserting mem_req; pc_q+cnt wrapping past 2^64-1 SHALL count as out-of-range.
REQ-022 On mem_ack with mem_err=1, go to ERR.
REQ-023 On mem_ack with mem_err=0, write mem_rdata to byte cnt and increment cnt.
REQ-024 Length SHALL be decoded from byte 0 bits [0:3] (icode): 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C..F -> 1.
REQ-025 When cnt reaches the decoded length, go to DONE; mem_req deasserts the following cycle; no further bytes are requested.
REQ-026 Unfetched bytes of instr SHALL read zero.
REQ-027 DONE: instr_valid=1, imem_error=0; on instr_ready=1 go to IDLE, instr_valid low next cycle.
REQ-028 ERR: instr_valid=1, imem_error=1, instr_len = bytes fetched so far (0 if none); on instr_ready go to IDLE.
REQ-029 instr, instr_len and imem_error SHALL be held stable while instr_valid=1 and instr_ready=0.
REQ-030 start and instr_ready high in the same cycle in DONE/ERR: handshake completes; start is ignored (new fetch needs start in IDLE).
REQ-031 Latency from start to instr_valid = 1 + sum of per-byte ack latencies + 1 cycle.

Reset
REQ-032 While rst_n=0 at a rising edge: state IDLE, cnt 0, instr 0, instr_len 0, mem_req 0, mem_addr 0, instr_valid 0, imem_error 0, busy 0.
REQ-033 Reset mid-fetch SHALL abandon the fetch; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-034 Macro IFETCH_TIMEOUT_EN: defined -> a wait counter counts REQ cycles without mem_ack, reset on every ack; reaching TIMEOUT goes to ERR and drops mem_req.
REQ-035 Macro IFETCH_TIMEOUT_EN undefined -> no counter; REQ waits indefinitely for mem_ack.

Structure
REQ-036 Package y86_pkg SHALL hold the icode constants, MAX_INSTR_BYTES=10 and the state enumeration.
REQ-037 Sub-module ilen_decode SHALL map icode to instr_len (purely combinational).

Verification
REQ-038 pc=0x10, bytes 30 F2 0A 00 00 00 00 00 00 00, 1-cycle acks -> 10 requests at 0x10..0x19; instr_len=10; instr[0:7]=0x30; imem_error=0.
REQ-039 pc=0x20, byte 0x60 then 0x23 -> exactly 2 requests; instr_len=2; instr[16:79]=0; DONE held across 3 cycles of instr_ready=0.
REQ-040 pc=1020, icode 7 (9 bytes) -> bytes 1020..1023 fetched, no request at 1024; ERR with instr_len=4, imem_error=1.
REQ-041 pc=0x40, mem_ack with mem_err=1 on the second byte -> ERR, instr_len=1; start during ERR ignored; IDLE after instr_ready.
REQ-042 IFETCH_TIMEOUT_EN, TIMEOUT=16, mem_ack never asserted -> ERR after 16 REQ cycles, mem_req low; undefined -> still in REQ after 100 cycles.
REQ-043 rst_n=0 during the fourth byte of a 10-byte fetch -> all outputs 0 next edge; stray mem_ack ignored; next start fetches cleanly.
